// File: rtl/elevator_shaft_model.sv
// elevator_shaft_model
//   Plant model of an elevator car in its shaft. It takes the controller's
//   motor command (ac) and door command (open), models travel time between
//   floors, and drives the one-hot floor sensors that the controller reads.
//   Illegal commands (moving with the door open, driving past a limit, ac=11,
//   reversing mid-travel) latch a sticky fault until reset.
//
//   Optional build macro: SHAFT_REVERSE_EN
//     defined   - an opposite ac command during travel is legal. The car turns
//                 around and comes back to the floor it left.
//     undefined - reversal mid-travel is a fault (code 11).
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ac         in   [1:0] motor command: 00 idle, 01 up, 10 down, 11 illegal
//   open       in   door command, 1 = open
//   sensors    out  [N_FLOORS-1:0] one-hot floor sensors, zero between floors
//   floor      out  [2:0] last floor reached (1..N_FLOORS)
//   moving     out  high while travelling with the counter advancing
//   arrive     out  one-cycle pulse when sensors become non-zero
//   fault      out  sticky fault flag
//   fault_code out  [1:0] 00 none, 01 door open, 10 limit/ac=11, 11 reversal
module elevator_shaft_model #(
    parameter int N_FLOORS    = 6,
    parameter int TRAVEL_CYC  = 8,
    parameter int START_FLOOR = 1,
    parameter int CW          = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          ac,
    input  logic                open,
    output logic [N_FLOORS-1:0] sensors,
    output logic [2:0]          floor,
    output logic                moving,
    output logic                arrive,
    output logic                fault,
    output logic [1:0]          fault_code
);

    typedef enum logic [1:0] {
        AT_FLOOR,
        TRAVEL,
        FAULT
    } state_t;

    localparam logic [N_FLOORS-1:0] SENS_ONE   = {{(N_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [N_FLOORS-1:0] SENS_START = SENS_ONE << (START_FLOOR - 1);
    localparam logic [2:0]          FLOOR_TOP  = 3'(N_FLOORS);
    localparam logic [2:0]          FLOOR_RST  = 3'(START_FLOOR);
    localparam logic [CW-1:0]       CNT_FULL   = CW'(TRAVEL_CYC);
    localparam logic [CW-1:0]       CNT_ONE    = CW'(1);

    state_t                state, state_n;
    logic [2:0]            floor_n;
    logic [2:0]            tgt, tgt_n;       // floor the car is heading for
    logic [CW-1:0]         count, count_n;   // matching-ac cycles left to arrival
    logic                  dir_up, dir_up_n; // latched direction, 1 = up
    logic [N_FLOORS-1:0]   sensors_n;
    logic                  moving_n, arrive_n, fault_n;
    logic [1:0]            fault_code_n;

    logic req_up, req_dn, req_bad;

    always_comb begin
        req_up  = (ac == 2'b01);
        req_dn  = (ac == 2'b10);
        req_bad = (ac == 2'b11);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= AT_FLOOR;
            floor      <= FLOOR_RST;
            tgt        <= FLOOR_RST;
            count      <= '0;
            dir_up     <= 1'b1;
            sensors    <= SENS_START;
            moving     <= 1'b0;
            arrive     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            state      <= state_n;
            floor      <= floor_n;
            tgt        <= tgt_n;
            count      <= count_n;
            dir_up     <= dir_up_n;
            sensors    <= sensors_n;
            moving     <= moving_n;
            arrive     <= arrive_n;
            fault      <= fault_n;
            fault_code <= fault_code_n;
        end
    end

    always_comb begin
        state_n      = state;
        floor_n      = floor;
        tgt_n        = tgt;
        count_n      = count;
        dir_up_n     = dir_up;
        sensors_n    = sensors;
        moving_n     = 1'b0;
        arrive_n     = 1'b0;
        fault_n      = fault;
        fault_code_n = fault_code;

        case (state)
            AT_FLOOR: begin
                if (ac != 2'b00) begin
                    if (open) begin
                        state_n      = FAULT;
                        fault_n      = 1'b1;
                        fault_code_n = 2'b01;
                    end else if (req_bad || (req_up && floor == FLOOR_TOP) ||
                                 (req_dn && floor == 3'd1)) begin
                        state_n      = FAULT;
                        fault_n      = 1'b1;
                        fault_code_n = 2'b10;
                    end else begin
                        state_n   = TRAVEL;
                        sensors_n = '0;
                        count_n   = CNT_FULL;
                        dir_up_n  = req_up;
                        tgt_n     = req_up ? floor + 3'd1 : floor - 3'd1;
                        moving_n  = 1'b1;
                    end
                end
            end

            TRAVEL: begin
                // Checks are ordered so that the highest-priority fault code wins.
                if (open) begin
                    state_n      = FAULT;
                    fault_n      = 1'b1;
                    fault_code_n = 2'b01;
                end else if (req_bad) begin
                    state_n      = FAULT;
                    fault_n      = 1'b1;
                    fault_code_n = 2'b10;
                end else if (ac == 2'b00) begin
                    // stall: car parked between floors, counter holds
                end else if (req_up == dir_up) begin
                    if (count == CNT_ONE) begin
                        state_n   = AT_FLOOR;
                        floor_n   = tgt;
                        sensors_n = SENS_ONE << (tgt - 3'd1);
                        arrive_n  = 1'b1;
                        count_n   = '0;
                    end else begin
                        count_n  = count - CNT_ONE;
                        moving_n = 1'b1;
                    end
                end else begin
`ifdef SHAFT_REVERSE_EN
                    // Turn around: heading back to the floor just left, or, if
                    // already returning, out again towards the neighbour floor.
                    dir_up_n = req_up;
                    count_n  = CNT_FULL - count + CNT_ONE;
                    tgt_n    = (tgt == floor) ? (req_up ? floor + 3'd1 : floor - 3'd1)
                                              : floor;
                    moving_n = 1'b1;
`else
                    state_n      = FAULT;
                    fault_n      = 1'b1;
                    fault_code_n = 2'b11;
`endif
                end
            end

            FAULT: begin
                // frozen until reset
            end

            default: begin
                state_n = FAULT;
                fault_n = 1'b1;
            end
        endcase
    end

endmodule
